// File: rtl/key_sequencer.sv
// Serial key loader that replays three keys in lock-step with a locked FSM's counter.
// Optional even-parity load check is enabled by defining KEYSEQ_PARITY_EN.
module key_sequencer #(
  parameter int KEY_W     = 11,
  parameter int PHASE_LEN = 6,
  parameter int NUM_KEYS  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             cfg_bit,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             armed,
  output logic [1:0]       phase,
  output logic             cfg_err
);

  localparam int PERIOD = PHASE_LEN * NUM_KEYS;
  localparam int CW     = $clog2(PERIOD);
  localparam int TOT    = KEY_W * NUM_KEYS;
  localparam int BW     = $clog2(TOT + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
`ifdef KEYSEQ_PARITY_EN
  localparam logic [1:0] S_CHECK = 2'd3;
`endif

  logic [CW-1:0]    cnt;
  logic [1:0]       state;
  logic [TOT-1:0]   keys;
  logic [BW-1:0]    bit_cnt;
  logic [KEY_W-1:0] key_sel;

  // Mirror of the locked FSM's counter; it advances on the falling edge.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt >= CW'(PERIOD - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    phase = '0;
    for (int k = 1; k < NUM_KEYS; k++) begin
      if (cnt >= CW'(k * PHASE_LEN)) begin
        phase = 2'(k);
      end
    end
  end

  always_comb begin
    key_sel = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (phase == 2'(k)) begin
        key_sel = keys[k*KEY_W +: KEY_W];
      end
    end
  end

  assign cfg_ready = (state == S_LOAD);

`ifdef KEYSEQ_PARITY_EN
  logic par;
  logic pbit;
  logic err;

  assign cfg_err = err;
`else
  assign cfg_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      keys    <= '0;
      bit_cnt <= '0;
      armed   <= 1'b0;
      key_out <= '0;
`ifdef KEYSEQ_PARITY_EN
      par     <= 1'b0;
      pbit    <= 1'b0;
      err     <= 1'b0;
`endif
    end else begin
      key_out <= (state == S_RUN && !load_start) ? key_sel : '0;
      if (load_start) begin
        state   <= S_LOAD;
        keys    <= '0;
        bit_cnt <= '0;
        armed   <= 1'b0;
`ifdef KEYSEQ_PARITY_EN
        par     <= 1'b0;
        err     <= 1'b0;
`endif
      end else begin
        unique case (1'b1)
          state == S_IDLE: ;
          state == S_RUN:  ;
          state == S_LOAD: begin
            if (cfg_valid) begin
`ifdef KEYSEQ_PARITY_EN
              if (bit_cnt == BW'(TOT)) begin
                pbit  <= cfg_bit;
                state <= S_CHECK;
              end else begin
                keys    <= {cfg_bit, keys[TOT-1:1]};
                par     <= par ^ cfg_bit;
                bit_cnt <= bit_cnt + 1'b1;
              end
`else
              // First bit shifts down to keys[0] once all bits are in.
              keys    <= {cfg_bit, keys[TOT-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BW'(TOT - 1)) begin
                state <= S_RUN;
                armed <= 1'b1;
              end
`endif
            end
          end
`ifdef KEYSEQ_PARITY_EN
          state == S_CHECK: begin
            if (pbit == par) begin
              state <= S_RUN;
              armed <= 1'b1;
            end else begin
              state <= S_IDLE;
              err   <= 1'b1;
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_sequencer.sv
// Directed bench for key_sequencer; define KEYSEQ_PARITY_EN to exercise the parity build.
module tb_key_sequencer;

`ifdef KEYSEQ_PARITY_EN
  localparam int  NB  = 34;
  localparam bit  PAR = 1'b1;
`else
  localparam int  NB  = 33;
  localparam bit  PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_start = 1'b0;
  logic        cfg_bit = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [10:0] key_out;
  logic        armed;
  logic [1:0]  phase;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;
  int mcnt = 0;

  logic [10:0] ka [3];
  logic [10:0] kb [3];
  logic [10:0] kc [3];
  logic [10:0] exp_k;
  logic [1:0]  exp_p;

  key_sequencer dut (
    .clk(clk),
    .rst(rst),
    .load_start(load_start),
    .cfg_bit(cfg_bit),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .key_out(key_out),
    .armed(armed),
    .phase(phase),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk or posedge rst) begin
    if (rst) mcnt = 0;
    else if (mcnt >= 17) mcnt = 0;
    else mcnt = mcnt + 1;
  end

  function automatic logic [33:0] pack(input logic [10:0] k0, input logic [10:0] k1,
                                       input logic [10:0] k2, input logic bad);
    logic p;
    p = ^{k2, k1, k0} ^ bad;
    return {p, k2, k1, k0};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load;
    load_start = 1'b1;
    cfg_valid  = 1'b0;
    step();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [33:0] v, input int from, input int to, input int gap);
    for (int i = from; i < to; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = v[i];
      step();
      cfg_valid = 1'b0;
      for (int g = 0; g < gap; g++) step();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++;
    if (key_out !== 11'd0) begin errors++; $display("FAIL rst_key got %h exp 000", key_out); end
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL rst_armed got %b exp 0", armed); end
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", cfg_ready); end
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", cfg_err); end
    checks++;
    if (phase !== 2'd0) begin errors++; $display("FAIL rst_phase got %0d exp 0", phase); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      exp_p = 2'(mcnt / 6);
      checks++;
      if (phase !== exp_p) begin errors++; $display("FAIL idle_phase got %0d exp %0d", phase, exp_p); end
      checks++;
      if (key_out !== 11'd0 || armed !== 1'b0) begin
        errors++;
        $display("FAIL idle_out got key %h armed %b exp 000 0", key_out, armed);
      end
    end
  endtask

  task automatic test_load_run;
    start_load();
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b exp 1", cfg_ready); end
    send(pack(ka[0], ka[1], ka[2], 1'b0), 0, NB, 0);
    if (PAR) step();
    checks++;
    if (armed !== 1'b1) begin errors++; $display("FAIL load_armed got %b exp 1", armed); end
    checks++;
    if (key_out !== 11'd0) begin errors++; $display("FAIL load_key0 got %h exp 000", key_out); end
    checks++;
    if (cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL load_done got ready %b err %b exp 0 0", cfg_ready, cfg_err);
    end
    for (int i = 0; i < 54; i++) begin
      step();
      exp_k = ka[mcnt / 6];
      exp_p = 2'(mcnt / 6);
      checks++;
      if (key_out !== exp_k) begin errors++; $display("FAIL run_key got %h exp %h", key_out, exp_k); end
      checks++;
      if (phase !== exp_p) begin errors++; $display("FAIL run_phase got %0d exp %0d", phase, exp_p); end
    end
  endtask

  task automatic test_abort;
    for (int i = 0; i < 40 && mcnt != 8; i++) step();
    checks++;
    if (mcnt != 8) begin errors++; $display("FAIL abort_wait got cnt %0d exp 8", mcnt); end
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    checks++;
    if (key_out !== 11'd0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL abort_out got key %h armed %b exp 000 0", key_out, armed);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", cfg_ready); end
    checks++;
    if (phase !== 2'd1) begin errors++; $display("FAIL abort_phase got %0d exp 1", phase); end
    send(pack(kb[0], kb[1], kb[2], 1'b0), 0, 5, 0);
    load_start = 1'b1;
    cfg_valid  = 1'b1;
    cfg_bit    = 1'b1;
    step();
    load_start = 1'b0;
    cfg_valid  = 1'b0;
    send(pack(kb[0], kb[1], kb[2], 1'b0), 0, NB, 0);
    if (PAR) step();
    checks++;
    if (armed !== 1'b1) begin errors++; $display("FAIL prio_armed got %b exp 1", armed); end
    for (int i = 0; i < 18; i++) begin
      step();
      exp_k = kb[mcnt / 6];
      checks++;
      if (key_out !== exp_k) begin errors++; $display("FAIL prio_key got %h exp %h", key_out, exp_k); end
    end
  endtask

  task automatic test_rst_mid_load;
    start_load();
    send(pack(ka[0], ka[1], ka[2], 1'b0), 0, 20, 0);
    rst = 1'b1;
    #2;
    checks++;
    if (armed !== 1'b0 || key_out !== 11'd0 || cfg_ready !== 1'b0 || phase !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid got armed %b key %h ready %b phase %0d exp 0 000 0 0",
               armed, key_out, cfg_ready, phase);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_idle got %b exp 0", cfg_ready); end
    start_load();
    send(pack(kc[0], kc[1], kc[2], 1'b0), 0, NB, 0);
    if (PAR) step();
    checks++;
    if (armed !== 1'b1) begin errors++; $display("FAIL reload_armed got %b exp 1", armed); end
    for (int i = 0; i < 18; i++) begin
      step();
      exp_k = kc[mcnt / 6];
      checks++;
      if (key_out !== exp_k) begin errors++; $display("FAIL reload_key got %h exp %h", key_out, exp_k); end
    end
  endtask

  task automatic test_toggle_valid;
    start_load();
    send(pack(ka[0], ka[1], ka[2], 1'b0), 0, NB - 1, 1);
    checks++;
    if (armed !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL toggle_early got armed %b ready %b exp 0 1", armed, cfg_ready);
    end
    send(pack(ka[0], ka[1], ka[2], 1'b0), NB - 1, NB, 0);
    if (PAR) step();
    checks++;
    if (armed !== 1'b1 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL toggle_done got armed %b ready %b exp 1 0", armed, cfg_ready);
    end
    for (int i = 0; i < 18; i++) begin
      step();
      exp_k = ka[mcnt / 6];
      checks++;
      if (key_out !== exp_k) begin errors++; $display("FAIL toggle_key got %h exp %h", key_out, exp_k); end
    end
  endtask

`ifdef KEYSEQ_PARITY_EN
  task automatic test_parity;
    start_load();
    send(pack(kb[0], kb[1], kb[2], 1'b1), 0, NB, 0);
    step();
    checks++;
    if (cfg_err !== 1'b1 || armed !== 1'b0) begin
      errors++;
      $display("FAIL par_bad got err %b armed %b exp 1 0", cfg_err, armed);
    end
    step();
    step();
    checks++;
    if (cfg_err !== 1'b1 || key_out !== 11'd0 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL par_hold got err %b key %h ready %b exp 1 000 0", cfg_err, key_out, cfg_ready);
    end
    start_load();
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL par_clear got %b exp 0", cfg_err); end
    send(pack(kb[0], kb[1], kb[2], 1'b0), 0, NB, 0);
    step();
    checks++;
    if (cfg_err !== 1'b0 || armed !== 1'b1) begin
      errors++;
      $display("FAIL par_good got err %b armed %b exp 0 1", cfg_err, armed);
    end
    for (int i = 0; i < 18; i++) begin
      step();
      exp_k = kb[mcnt / 6];
      checks++;
      if (key_out !== exp_k) begin errors++; $display("FAIL par_key got %h exp %h", key_out, exp_k); end
    end
  endtask
`endif

  initial begin
    ka[0] = 11'b01111010111;
    ka[1] = 11'b01001101000;
    ka[2] = 11'b11011110010;
    kb[0] = 11'h2B1;
    kb[1] = 11'h0F7;
    kb[2] = 11'h64E;
    kc[0] = 11'h5A5;
    kc[1] = 11'h13C;
    kc[2] = 11'h7F0;
    test_reset();
    test_load_run();
    test_abort();
    test_rst_mid_load();
    test_toggle_valid();
`ifdef KEYSEQ_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
